mem_burst_master: RTL and testbench

MEM_BURST_MASTER -- requirements
Module: mem_burst_master

---
 rtl/mem_burst_master.sv | 142 ++++++++++++++
 tb/tb_mem_burst_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// Burst master that turns single read/write burst commands into per-beat accesses
// on a simple synchronous memory port, with a 4-deep response FIFO for reads.
module mem_burst_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_wr,
  input  logic [7:0]  i_cmd_addr,
  input  logic [7:0]  i_cmd_len,
  input  logic        i_wdata_valid,
  output logic        o_wdata_ready,
  input  logic [31:0] i_wdata,
  output logic        o_rdata_valid,
  input  logic        i_rdata_ready,
  output logic [31:0] o_rdata,
  output logic        o_rdata_last,
  output logic        o_mem_wr_en,
  output logic [7:0]  o_mem_addr,
  output logic [31:0] o_mem_data,
  input  logic [31:0] i_mem_data,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t      state;
  logic [7:0]  addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat;

  // Read pipeline: stage 1 = address on memory port, stage 2 = memory registering data.
  logic        iss_v1;
  logic        iss_v2;
  logic        iss_l1;
  logic        iss_l2;

  logic [31:0] fifo_data [4];
  logic [3:0]  fifo_last;
  logic [1:0]  wptr;
  logic [1:0]  rptr;
  logic [2:0]  count;

  logic [2:0]  inflight;
  logic        issue;
  logic        push;
  logic        pop;

  // Every channel is valid/ready: a transfer happens on a rising edge where both are
  // high; the source holds data stable while valid is high and ready is low.
  assign o_cmd_ready   = (state == IDLE);
  assign o_wdata_ready = (state == WRITE);
  assign o_busy        = (state != IDLE);
  assign o_rdata_valid = (count != 3'd0);
  assign o_rdata       = o_rdata_valid ? fifo_data[rptr] : 32'd0;
  assign o_rdata_last  = o_rdata_valid & fifo_last[rptr];

  // Credits cover FIFO entries plus data still travelling, so a push never hits a full FIFO.
  always_comb begin
    inflight = {2'b00, iss_v1} + {2'b00, iss_v2};
    issue    = (state == READ) && ((count + inflight) < 3'd4);
    push     = iss_v2;
    pop      = o_rdata_valid & i_rdata_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= 8'd0;
      len_q       <= 8'd0;
      beat        <= 8'd0;
      o_mem_wr_en <= 1'b0;
      o_mem_addr  <= 8'd0;
      o_mem_data  <= 32'd0;
    end else begin
      o_mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            addr_q <= i_cmd_addr;
            len_q  <= i_cmd_len;
            beat   <= 8'd0;
            state  <= i_cmd_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (i_wdata_valid) begin
            o_mem_wr_en <= 1'b1;
            o_mem_addr  <= addr_q + beat;
            o_mem_data  <= i_wdata;
            beat        <= beat + 8'd1;
            if (beat == len_q) state <= IDLE;
          end
        end
        READ: begin
          if (issue) begin
            o_mem_addr <= addr_q + beat;
            beat       <= beat + 8'd1;
            if (beat == len_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!iss_v1 && !iss_v2 && (count == 3'd0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_v1 <= 1'b0;
      iss_v2 <= 1'b0;
      iss_l1 <= 1'b0;
      iss_l2 <= 1'b0;
      wptr   <= 2'd0;
      rptr   <= 2'd0;
      count  <= 3'd0;
    end else begin
      iss_v1 <= issue;
      iss_l1 <= issue && (beat == len_q);
      iss_v2 <= iss_v1;
      iss_l2 <= iss_l1;
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr] <= i_mem_data;
      fifo_last[wptr] <= iss_l2;
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master: behavioural memory, scoreboard queues for
// memory writes and read beats, and checks on latency, backpressure, wrap and reset.
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_wr;
  logic [7:0]  i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic        i_wdata_valid;
  logic        o_wdata_ready;
  logic [31:0] i_wdata;
  logic        o_rdata_valid;
  logic        i_rdata_ready;
  logic [31:0] o_rdata;
  logic        o_rdata_last;
  logic        o_mem_wr_en;
  logic [7:0]  o_mem_addr;
  logic [31:0] o_mem_data;
  logic [31:0] mem_rdata;
  logic        o_busy;

  always #5 clk = ~clk;

  mem_burst_master dut (
    .clk           (clk),
    .rst           (rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_wr      (i_cmd_wr),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_len     (i_cmd_len),
    .i_wdata_valid (i_wdata_valid),
    .o_wdata_ready (o_wdata_ready),
    .i_wdata       (i_wdata),
    .o_rdata_valid (o_rdata_valid),
    .i_rdata_ready (i_rdata_ready),
    .o_rdata       (o_rdata),
    .o_rdata_last  (o_rdata_last),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_addr    (o_mem_addr),
    .o_mem_data    (o_mem_data),
    .i_mem_data    (mem_rdata),
    .o_busy        (o_busy)
  );

  // Synchronous memory with one-cycle registered read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (o_mem_wr_en) mem[o_mem_addr] <= o_mem_data;
    mem_rdata <= mem[o_mem_addr];
  end

  int          errors = 0;
  int          checks = 0;
  int          issue_cnt = 0;
  logic [7:0]  prev_addr = 8'd0;
  logic [39:0] wr_exp_q [$];
  logic [32:0] rd_exp_q [$];
  logic [31:0] model_mem [256];
  logic [31:0] wbuf [256];

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, then return 2 time units past the rising edge.
  task automatic tick();
    logic [39:0] we;
    logic [32:0] re;
    @(negedge clk);
    if (o_mem_wr_en) begin
      check("wr_strobe_expected", 40'(wr_exp_q.size() != 0), 40'd1);
      if (wr_exp_q.size() != 0) begin
        we = wr_exp_q.pop_front();
        check("wr_addr_data", {o_mem_addr, o_mem_data}, we);
      end
    end
    if (o_rdata_valid && i_rdata_ready) begin
      check("rd_beat_expected", 40'(rd_exp_q.size() != 0), 40'd1);
      if (rd_exp_q.size() != 0) begin
        re = rd_exp_q.pop_front();
        check("rd_last_data", 40'({o_rdata_last, o_rdata}), 40'(re));
      end
    end
    if (!o_mem_wr_en && (o_mem_addr != prev_addr)) issue_cnt++;
    prev_addr = o_mem_addr;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 300) begin
      tick();
      n++;
    end
    check(tag, 40'(o_busy), 40'd0);
  endtask

  task automatic do_write(input logic [7:0] addr, input int len, input bit gaps, input bit busy_cmd);
    logic [7:0] a;
    int k;
    i_cmd_valid = 1'b1;
    i_cmd_wr    = 1'b1;
    i_cmd_addr  = addr;
    i_cmd_len   = 8'(len);
    tick();
    check("wr_accept_busy", 40'(o_busy), 40'd1);
    i_cmd_valid = busy_cmd;
    i_cmd_wr    = 1'b0;
    i_cmd_addr  = 8'h99;
    i_cmd_len   = 8'd5;
    k = 0;
    while (k <= len) begin
      check("wr_wdata_ready", 40'(o_wdata_ready), 40'd1);
      if (busy_cmd) check("busy_cmd_ready_low", 40'(o_cmd_ready), 40'd0);
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_wdata_valid = 1'b0;
        i_wdata       = $urandom;
      end else begin
        a = addr + 8'(k);
        i_wdata_valid = 1'b1;
        i_wdata       = wbuf[k];
        wr_exp_q.push_back({a, wbuf[k]});
        model_mem[a] = wbuf[k];
        if (k == len) i_cmd_valid = 1'b0;
        k++;
      end
      tick();
    end
    i_wdata_valid = 1'b0;
    check("wr_idle_after_last", 40'({o_busy, o_cmd_ready}), 40'b01);
    tick();
    check("wr_all_strobes_seen", 40'(wr_exp_q.size()), 40'd0);
    check("wr_strobe_single", 40'(o_mem_wr_en), 40'd0);
  endtask

  task automatic push_read_exp(input logic [7:0] addr, input int len);
    logic [7:0] a;
    for (int k = 0; k <= len; k++) begin
      a = addr + 8'(k);
      rd_exp_q.push_back({(k == len), model_mem[a]});
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input int len, input int stall);
    int lat;
    int base;
    logic [31:0] held;
    push_read_exp(addr, len);
    i_rdata_ready = (stall == 0);
    i_cmd_valid   = 1'b1;
    i_cmd_wr      = 1'b0;
    i_cmd_addr    = addr;
    i_cmd_len     = 8'(len);
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_addr  = 8'(~addr);
    if (stall == 0) begin
      lat = 0;
      while (!o_rdata_valid && lat < 20) begin
        tick();
        lat++;
      end
      check("rd_first_latency", 40'(lat), 40'd3);
      for (int k = 0; k <= len; k++) begin
        check("rd_streaming_valid", 40'(o_rdata_valid), 40'd1);
        tick();
      end
    end else begin
      base = issue_cnt;
      held = 32'd0;
      for (int c = 1; c <= stall; c++) begin
        tick();
        if (c == 3) held = o_rdata;
        if (c > 3) begin
          check("stall_valid_held", 40'(o_rdata_valid), 40'd1);
          check("stall_data_stable", 40'(o_rdata), 40'(held));
        end
      end
      check("stall_issue_limit", 40'((issue_cnt - base) <= 4), 40'd1);
      i_rdata_ready = 1'b1;
    end
    wait_idle("rd_returns_idle");
    check("rd_all_beats_seen", 40'(rd_exp_q.size()), 40'd0);
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    i_cmd_valid   = 1'b0;
    i_cmd_wr      = 1'b0;
    i_cmd_addr    = 8'd0;
    i_cmd_len     = 8'd0;
    i_wdata_valid = 1'b0;
    i_wdata       = 32'd0;
    i_rdata_ready = 1'b0;
    @(posedge clk);
    #2;
    tick();
    check("rst_outputs_zero",
          40'({o_busy, o_wdata_ready, o_rdata_valid, o_rdata_last, o_mem_wr_en}), 40'd0);
    check("rst_mem_addr", 40'(o_mem_addr), 40'd0);
    check("rst_mem_data", 40'(o_mem_data), 40'd0);
    check("rst_rdata", 40'(o_rdata), 40'd0);
    rst = 1'b0;
    tick();
    check("cmd_ready_after_rst", 40'(o_cmd_ready), 40'd1);

    // Single-beat write.
    wbuf[0] = 32'hDEADBEEF;
    do_write(8'h10, 0, 1'b0, 1'b0);

    // Four beats then read back with the consumer always ready.
    for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
    do_write(8'h20, 3, 1'b0, 1'b0);
    do_read(8'h20, 3, 0);

    // Address wrap around 0xFF, with write-data stalls.
    for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
    do_write(8'hFE, 3, 1'b1, 1'b0);
    do_read(8'hFE, 3, 0);

    // Consumer backpressure during an 8-beat read.
    for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
    do_write(8'h40, 7, 1'b1, 1'b0);
    do_read(8'h40, 7, 10);

    // Reset while beat 2 of an 8-beat read sits at the FIFO head.
    push_read_exp(8'h40, 7);
    i_rdata_ready = 1'b1;
    i_cmd_valid   = 1'b1;
    i_cmd_wr      = 1'b0;
    i_cmd_addr    = 8'h40;
    i_cmd_len     = 8'd7;
    tick();
    i_cmd_valid = 1'b0;
    n = 0;
    while (!o_rdata_valid && n < 20) begin
      tick();
      n++;
    end
    check("rst_test_first_beat", 40'(o_rdata_valid), 40'd1);
    tick();
    tick();
    rst           = 1'b1;
    i_rdata_ready = 1'b0;
    tick();
    check("rst_mid_read_valid_busy", 40'({o_rdata_valid, o_busy}), 40'd0);
    rd_exp_q.delete();
    rst = 1'b0;
    tick();
    check("cmd_ready_after_mid_rst", 40'(o_cmd_ready), 40'd1);
    i_rdata_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("no_rdata_after_rst", 40'({o_rdata_valid, o_mem_wr_en}), 40'd0);
      tick();
    end

    // Command presented while a write burst is in progress.
    for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
    do_write(8'h60, 3, 1'b1, 1'b1);
    do_read(8'h60, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
